// File: rtl/beat_address_sequencer.sv
// Record/playback address generator for the beat RAM: write strobes on key change, timed read stepping.
// Build option: define LOOP_PLAYBACK_EN to wrap playback to address 0 instead of stopping.
//
// state  | meaning
// IDLE   | address parked at 0, waiting for rec_en or play_en
// REC    | writing one entry per key-code change until buffer full
// PLAY   | stepping read address every TICK_DIV cycles
// DONE   | playback finished (or nothing recorded), address held
module beat_address_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int CODE_W    = 7,
    parameter int TICK_DIV  = 50000000,
    parameter int IDLE_CODE = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rec_en,
    input  logic              play_en,
    input  logic [CODE_W-1:0] ascii,
    output logic [ADDR_W-1:0] addressOut,
    output logic              wr_pulse,
    output logic [ADDR_W:0]   rec_len,
    output logic              full,
    output logic              play_done,
    output logic              wrap_pulse
);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(TICK_DIV - 1);
    localparam logic [CODE_W-1:0] IDLE_C    = CODE_W'(IDLE_CODE);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   count, count_nxt, count_inc;
    logic [CODE_W-1:0] prev_code, prev_code_nxt;
    logic [TICK_W-1:0] tick, tick_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W:0]   rec_len_nxt;
    logic              wr_nxt, full_nxt, done_nxt;
    logic              at_end, step;
`ifdef LOOP_PLAYBACK_EN
    logic              wrap_nxt;
`endif

    assign count_inc = count + 1'b1;
    assign at_end    = ({1'b0, addressOut} == (rec_len - 1'b1));
    assign step      = (state == S_PLAY) && play_en && (rec_len != '0) && (tick == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            count      <= '0;
            prev_code  <= IDLE_C;
            tick       <= TICK_LOAD;
            addressOut <= '0;
            wr_pulse   <= 1'b0;
            rec_len    <= '0;
            full       <= 1'b0;
            play_done  <= 1'b0;
`ifdef LOOP_PLAYBACK_EN
            wrap_pulse <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            prev_code  <= prev_code_nxt;
            tick       <= tick_nxt;
            addressOut <= addr_nxt;
            wr_pulse   <= wr_nxt;
            rec_len    <= rec_len_nxt;
            full       <= full_nxt;
            play_done  <= done_nxt;
`ifdef LOOP_PLAYBACK_EN
            wrap_pulse <= wrap_nxt;
`endif
        end
    end

`ifndef LOOP_PLAYBACK_EN
    assign wrap_pulse = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rec_en)       state_nxt = S_REC;
                else if (play_en) state_nxt = S_PLAY;
            end
            S_REC:  if (!rec_en) state_nxt = S_IDLE;
            S_PLAY: begin
                if (!play_en)              state_nxt = S_IDLE;
                else if (rec_len == '0)    state_nxt = S_DONE;
`ifndef LOOP_PLAYBACK_EN
                else if (step && at_end)   state_nxt = S_DONE;
`endif
            end
            default: if (!play_en) state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        count_nxt     = count;
        prev_code_nxt = prev_code;
        tick_nxt      = tick;
        addr_nxt      = addressOut;
        wr_nxt        = 1'b0;
        rec_len_nxt   = rec_len;
        full_nxt      = full;
        done_nxt      = play_done;
`ifdef LOOP_PLAYBACK_EN
        wrap_nxt      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                addr_nxt = '0;
                if (rec_en) begin
                    count_nxt     = '0;
                    prev_code_nxt = IDLE_C;
                    full_nxt      = 1'b0;
                end else if (play_en) begin
                    tick_nxt = TICK_LOAD;
                    done_nxt = 1'b0;
                end
            end
            S_REC: begin
                if (!rec_en) begin
                    rec_len_nxt = count;
                    addr_nxt    = '0;
                end else if ((ascii != prev_code) && !count[ADDR_W]) begin
                    addr_nxt      = count[ADDR_W-1:0];
                    wr_nxt        = 1'b1;
                    count_nxt     = count_inc;
                    prev_code_nxt = ascii;
                    full_nxt      = count_inc[ADDR_W];
                end
            end
            S_PLAY: begin
                if (!play_en) begin
                    addr_nxt = '0;
                end else if (rec_len == '0) begin
`ifndef LOOP_PLAYBACK_EN
                    done_nxt = 1'b1;
`endif
                end else if (step) begin
                    tick_nxt = TICK_LOAD;
                    if (!at_end) begin
                        addr_nxt = addressOut + 1'b1;
                    end else begin
`ifdef LOOP_PLAYBACK_EN
                        addr_nxt = '0;
                        wrap_nxt = 1'b1;
`else
                        done_nxt = 1'b1;
`endif
                    end
                end else begin
                    tick_nxt = tick - 1'b1;
                end
            end
            default: begin
                if (!play_en) begin
                    addr_nxt = '0;
                    done_nxt = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_beat_address_sequencer.sv
// Directed self-checking bench for beat_address_sequencer (ADDR_W=2, TICK_DIV=4).
// Expectations follow LOOP_PLAYBACK_EN when it is defined for the build.
module tb_beat_address_sequencer;

    localparam int ADDR_W = 2;
    localparam int CODE_W = 7;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              rec_en = 1'b0;
    logic              play_en = 1'b0;
    logic [CODE_W-1:0] ascii = 7'd32;
    logic [ADDR_W-1:0] addressOut;
    logic              wr_pulse;
    logic [ADDR_W:0]   rec_len;
    logic              full;
    logic              play_done;
    logic              wrap_pulse;

    int checks = 0;
    int errors = 0;

    beat_address_sequencer #(
        .ADDR_W(ADDR_W), .CODE_W(CODE_W), .TICK_DIV(4), .IDLE_CODE(32)
    ) dut (
        .clk(clk), .resetn(resetn), .rec_en(rec_en), .play_en(play_en),
        .ascii(ascii), .addressOut(addressOut), .wr_pulse(wr_pulse),
        .rec_len(rec_len), .full(full), .play_done(play_done), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rec_code(input logic [CODE_W-1:0] code, input logic exp_wr,
                            input logic [ADDR_W-1:0] exp_addr, input logic exp_full);
        ascii = code;
        cyc();
        check("rec_wr", 32'(wr_pulse), 32'(exp_wr));
        if (exp_wr) check("rec_addr", 32'(addressOut), 32'(exp_addr));
        check("rec_full", 32'(full), 32'(exp_full));
    endtask

    initial begin
        int exp_addr;
        logic exp_done, exp_wrap;

        // reset values
        cyc(); cyc();
        check("rst_addr", 32'(addressOut), 0);
        check("rst_wr", 32'(wr_pulse), 0);
        check("rst_len", 32'(rec_len), 0);
        check("rst_full", 32'(full), 0);
        check("rst_done", 32'(play_done), 0);
        check("rst_wrap", 32'(wrap_pulse), 0);
        resetn = 1'b1;
        cyc();

        // codes 32,65,65,66,32: first 32 matches the preload
        rec_en = 1'b1; ascii = 7'd32;
        cyc();
        rec_code(7'd32, 1'b0, 2'd0, 1'b0);
        rec_code(7'd65, 1'b1, 2'd0, 1'b0);
        rec_code(7'd65, 1'b0, 2'd0, 1'b0);
        rec_code(7'd66, 1'b1, 2'd1, 1'b0);
        rec_code(7'd32, 1'b1, 2'd2, 1'b0);
        rec_en = 1'b0;
        cyc();
        check("rec1_len", 32'(rec_len), 3);
        check("rec1_idle_addr", 32'(addressOut), 0);

        // fill a 4-entry buffer; fifth change ignored
        rec_en = 1'b1; ascii = 7'd32;
        cyc();
        rec_code(7'd1, 1'b1, 2'd0, 1'b0);
        rec_code(7'd2, 1'b1, 2'd1, 1'b0);
        rec_code(7'd3, 1'b1, 2'd2, 1'b0);
        rec_code(7'd4, 1'b1, 2'd3, 1'b1);
        rec_code(7'd5, 1'b0, 2'd0, 1'b1);
        check("full_addr_hold", 32'(addressOut), 3);
        rec_en = 1'b0;
        cyc();
        check("rec2_len", 32'(rec_len), 4);
        check("rec2_full_hold", 32'(full), 1);

        // three-entry recording for playback; full cleared on entry
        rec_en = 1'b1; ascii = 7'd32;
        cyc();
        check("rec3_full_clr", 32'(full), 0);
        rec_code(7'd10, 1'b1, 2'd0, 1'b0);
        rec_code(7'd11, 1'b1, 2'd1, 1'b0);
        rec_code(7'd12, 1'b1, 2'd2, 1'b0);
        rec_en = 1'b0;
        cyc();
        check("rec3_len", 32'(rec_len), 3);

        // playback, step every 4 cycles
        play_en = 1'b1;
        cyc();
        check("play_entry_addr", 32'(addressOut), 0);
        check("play_entry_done", 32'(play_done), 0);
        for (int k = 1; k <= 16; k++) begin
            cyc();
`ifdef LOOP_PLAYBACK_EN
            exp_addr = (k / 4) % 3;
            exp_done = 1'b0;
            exp_wrap = (k == 12);
`else
            exp_addr = (k >= 8) ? 2 : ((k >= 4) ? 1 : 0);
            exp_done = (k >= 12);
            exp_wrap = 1'b0;
`endif
            check($sformatf("play_addr_k%0d", k), 32'(addressOut), 32'(exp_addr));
            check($sformatf("play_done_k%0d", k), 32'(play_done), 32'(exp_done));
            check($sformatf("play_wrap_k%0d", k), 32'(wrap_pulse), 32'(exp_wrap));
        end
        play_en = 1'b0;
        cyc();
        check("play_exit_addr", 32'(addressOut), 0);
        check("play_exit_done", 32'(play_done), 0);

        // asynchronous reset mid-recording
        rec_en = 1'b1; ascii = 7'd32;
        cyc();
        rec_code(7'd40, 1'b1, 2'd0, 1'b0);
        rec_code(7'd41, 1'b1, 2'd1, 1'b0);
        resetn = 1'b0;
        #2;
        check("arst_addr", 32'(addressOut), 0);
        check("arst_wr", 32'(wr_pulse), 0);
        check("arst_len", 32'(rec_len), 0);
        check("arst_full", 32'(full), 0);
        rec_en = 1'b0;
        cyc();
        resetn = 1'b1;
        cyc();

        // simultaneous requests: record wins
        rec_en = 1'b1; play_en = 1'b1; ascii = 7'd32;
        cyc();
        rec_code(7'd7, 1'b1, 2'd0, 1'b0);
        rec_en = 1'b0; play_en = 1'b0;
        cyc();
        check("both_len", 32'(rec_len), 1);

        // empty recording then playback goes straight to DONE
        rec_en = 1'b1; ascii = 7'd32;
        cyc();
        cyc();
        rec_en = 1'b0;
        cyc();
        check("empty_len", 32'(rec_len), 0);
        play_en = 1'b1;
        cyc();
        cyc();
`ifdef LOOP_PLAYBACK_EN
        check("empty_done", 32'(play_done), 0);
`else
        check("empty_done", 32'(play_done), 1);
`endif
        check("empty_addr", 32'(addressOut), 0);
        // record request while in DONE is ignored
        rec_en = 1'b1; ascii = 7'd50;
        cyc();
        check("done_rec_ignored", 32'(wr_pulse), 0);
        rec_en = 1'b0; play_en = 1'b0;
        cyc();
        check("done_exit_done", 32'(play_done), 0);
        check("done_exit_addr", 32'(addressOut), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
